grv_pair_serializer: RTL and testbench

GRV_PAIR_SERIALIZER -- requirements
Module: grv_pair_serializer

---
 rtl/grv_pair_serializer.sv | 105 ++++++++++
 tb/tb_grv_pair_serializer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/grv_pair_serializer.sv
// grv_pair_serializer: FIFO of (grv1, grv2) pairs emitted as a serial stream, grv1 then grv2.
// Define GRV_DROP_CNT_EN to build the saturating dropped-pair counter; otherwise drop_cnt reads zero.
module grv_pair_serializer #(
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [15:0]            grv1,
   input  logic [15:0]            grv2,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [15:0]            sample_o,
   output logic                   sample_valid,
   input  logic                   sample_ready,
   output logic                   overflow,
   output logic [15:0]            drop_cnt,
   output logic [$clog2(DEPTH):0] fill_level
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [AW:0] FULL_CNT = CW'(DEPTH);
   localparam logic [1:0] ST_EMPTY = 2'd0, ST_FIRST = 2'd1, ST_SECOND = 2'd2;
   logic [15:0]   mem1_q [DEPTH];
   logic [15:0]   mem2_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic [1:0]    state_q, state_d;
   logic [15:0]   sample_q, sample_d, nxt_g1;
   logic          valid_q, valid_d, ovf_q;
   logic          full, push, drop, pop;
   always_comb begin
      full     = count_q == FULL_CNT;
      push     = reset & in_valid & ~full;
      drop     = reset & in_valid & full;
      pop      = (state_q == ST_SECOND) & sample_ready;
      count_d  = count_q + CW'(push) - CW'(pop);
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      // A pair pushed on the same edge its predecessor leaves is not in memory yet.
      nxt_g1   = (count_q == CW'(1)) ? grv1 : mem1_q[rd_ptr_q + AW'(1)];
      state_d  = state_q;
      sample_d = sample_q;
      valid_d  = valid_q;
      case (state_q)
         ST_EMPTY: if (count_q != '0) begin
            state_d  = ST_FIRST;
            sample_d = mem1_q[rd_ptr_q];
            valid_d  = 1'b1;
         end
         ST_FIRST: if (sample_ready) begin
            state_d  = ST_SECOND;
            sample_d = mem2_q[rd_ptr_q];
         end
         ST_SECOND: if (sample_ready) begin
            state_d  = (count_d != '0) ? ST_FIRST : ST_EMPTY;
            sample_d = (count_d != '0) ? nxt_g1 : sample_q;
            valid_d  = count_d != '0;
         end
         default: begin
            state_d = ST_EMPTY;
            valid_d = 1'b0;
         end
      endcase
   end
   always_ff @(posedge clk) begin
      if (push) begin
         mem1_q[wr_ptr_q] <= grv1;
         mem2_q[wr_ptr_q] <= grv2;
      end
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         state_q  <= ST_EMPTY;
         sample_q <= 16'h0000;
         valid_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         state_q  <= state_d;
         sample_q <= sample_d;
         valid_q  <= valid_d;
         ovf_q    <= ovf_q | drop;
      end
   end
`ifdef GRV_DROP_CNT_EN
   logic [15:0] drop_cnt_q;
   always_ff @(posedge clk) begin
      if (!reset) drop_cnt_q <= 16'h0000;
      else if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
   end
   assign drop_cnt = drop_cnt_q;
`else
   assign drop_cnt = 16'h0000;
`endif
   assign in_ready     = ~full;
   assign sample_o     = sample_q;
   assign sample_valid = valid_q;
   assign overflow     = ovf_q;
   assign fill_level   = count_q;
endmodule

// File: tb/tb_grv_pair_serializer.sv
// tb_grv_pair_serializer: directed sequence plus per-cycle scoreboard for grv_pair_serializer.
module tb_grv_pair_serializer;
   localparam int DEPTH = 8;
`ifdef GRV_DROP_CNT_EN
   localparam bit DROP_EN = 1'b1;
`else
   localparam bit DROP_EN = 1'b0;
`endif
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] grv1 = '0, grv2 = '0;
   logic        in_valid = 1'b0, sample_ready = 1'b0;
   logic        in_ready, sample_valid, overflow;
   logic [15:0] sample_o, drop_cnt;
   logic [3:0]  fill_level;
   int          vectors = 0, miscompares = 0, nout = 0;
   logic [15:0] sb [$];
   logic        movf = 1'b0;
   logic [15:0] mdrop = '0;

   grv_pair_serializer #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .grv1(grv1), .grv2(grv2), .in_valid(in_valid),
      .in_ready(in_ready), .sample_o(sample_o), .sample_valid(sample_valid),
      .sample_ready(sample_ready), .overflow(overflow), .drop_cnt(drop_cnt),
      .fill_level(fill_level)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: queue of expected samples; stored pairs = ceil(entries/2).
   always @(negedge clk) begin
      int mcnt;
      logic [15:0] exp;
      if (!reset) begin
         sb.delete();
         movf  = 1'b0;
         mdrop = '0;
      end else begin
         mcnt = (sb.size() + 1) / 2;
         chk("in_ready", 32'(in_ready), 32'(mcnt < DEPTH));
         chk("fill_level", 32'(fill_level), 32'(mcnt));
         chk("overflow", 32'(overflow), 32'(movf));
         chk("drop_cnt", 32'(drop_cnt), 32'(mdrop));
         if (sample_valid && sample_ready) begin
            if (sb.size() == 0) chk("sample_extra", 32'(sample_o), 32'hDEAD_BEEF);
            else begin
               exp = sb.pop_front();
               chk("sample", 32'(sample_o), 32'(exp));
               nout++;
            end
         end
         if (in_valid) begin
            if (mcnt < DEPTH) begin
               sb.push_back(grv1);
               sb.push_back(grv2);
            end else begin
               movf = 1'b1;
               if (DROP_EN && mdrop != 16'hFFFF) mdrop = mdrop + 16'd1;
            end
         end
      end
   end

   initial begin
      int sent, base;
      repeat (3) tick();
      chk("rst_valid", 32'(sample_valid), 0);
      chk("rst_sample", 32'(sample_o), 0);
      chk("rst_fill", 32'(fill_level), 0);
      chk("rst_ovf", 32'(overflow), 0);
      chk("rst_drop", 32'(drop_cnt), 0);
      reset = 1'b1;
      tick();
      chk("rel_in_ready", 32'(in_ready), 1);
      // Single pair, consumer always ready
      sample_ready = 1'b1;
      grv1 = 16'h0123; grv2 = 16'hFEDC; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("lat_valid0", 32'(sample_valid), 0);
      chk("lat_fill", 32'(fill_level), 1);
      tick();
      chk("pair_v1", 32'(sample_valid), 1);
      chk("pair_s1", 32'(sample_o), 32'h0123);
      tick();
      chk("pair_v2", 32'(sample_valid), 1);
      chk("pair_s2", 32'(sample_o), 32'hFEDC);
      chk("pair_fill_head", 32'(fill_level), 1);
      tick();
      chk("pair_empty", 32'(sample_valid), 0);
      chk("pair_fill0", 32'(fill_level), 0);
      // Fill to capacity with consumer stalled, ninth pair dropped
      sample_ready = 1'b0;
      for (int i = 0; i < 9; i++) begin
         grv1 = 16'(16'h1000 + i); grv2 = 16'(16'h2000 + i); in_valid = 1'b1;
         chk("fill_in_ready", 32'(in_ready), 32'(i < 8));
         tick();
      end
      in_valid = 1'b0;
      chk("full_ovf", 32'(overflow), 1);
      chk("full_drop", 32'(drop_cnt), DROP_EN ? 1 : 0);
      chk("full_fill", 32'(fill_level), 8);
      chk("full_in_ready", 32'(in_ready), 0);
      chk("full_head", 32'(sample_o), 32'h1000);
      // Pop and rejected push on the same edge
      sample_ready = 1'b1;
      tick();
      chk("second_head", 32'(sample_o), 32'h2000);
      grv1 = 16'hAAAA; grv2 = 16'hBBBB; in_valid = 1'b1;
      chk("pp_in_ready", 32'(in_ready), 0);
      tick();
      in_valid = 1'b0; sample_ready = 1'b0;
      chk("pp_in_ready_after", 32'(in_ready), 1);
      chk("pp_fill", 32'(fill_level), 7);
      chk("pp_drop", 32'(drop_cnt), DROP_EN ? 2 : 0);
      chk("pp_next", 32'(sample_o), 32'h1001);
      // Stall in SECOND
      sample_ready = 1'b1;
      tick();
      sample_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("hold_sample", 32'(sample_o), 32'h2001);
         chk("hold_fill", 32'(fill_level), 7);
         chk("hold_valid", 32'(sample_valid), 1);
      end
      sample_ready = 1'b1;
      tick();
      chk("hold_pop_fill", 32'(fill_level), 6);
      chk("hold_pop_next", 32'(sample_o), 32'h1002);
      // Reset while half-emitted with 3 pairs stored; push during reset ignored
      repeat (7) tick();
      chk("mid_sample", 32'(sample_o), 32'h2005);
      chk("mid_fill", 32'(fill_level), 3);
      sample_ready = 1'b0; reset = 1'b0;
      grv1 = 16'h5555; grv2 = 16'h6666; in_valid = 1'b1;
      tick();
      reset = 1'b1; in_valid = 1'b0;
      chk("mrst_valid", 32'(sample_valid), 0);
      chk("mrst_fill", 32'(fill_level), 0);
      chk("mrst_ovf", 32'(overflow), 0);
      chk("mrst_drop", 32'(drop_cnt), 0);
      chk("mrst_sample", 32'(sample_o), 0);
      tick();
      chk("mrst_fill2", 32'(fill_level), 0);
      chk("mrst_valid2", 32'(sample_valid), 0);
      chk("mrst_in_ready", 32'(in_ready), 1);
      // Stream 40 pairs with toggling consumer, across pointer wrap
      sent = 0;
      base = nout;
      for (int c = 0; c < 2000 && !(sent == 40 && sb.size() == 0); c++) begin
         sample_ready = c[0];
         in_valid = (sent < 40) && in_ready;
         grv1 = 16'($urandom); grv2 = 16'($urandom);
         if (in_valid) sent++;
         tick();
      end
      in_valid = 1'b0;
      chk("stream_sent", 32'(sent), 40);
      chk("stream_count", 32'(nout - base), 80);
      chk("stream_drained", 32'(sb.size()), 0);
      chk("stream_end_valid", 32'(sample_valid), 0);
      chk("stream_drop", 32'(drop_cnt), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
